// File: rtl/video_fetch.sv
// Video line fetcher: issues SRAM word addresses in the controller's video
// address slot, captures read data in the data slot, and buffers words in a
// small FIFO for the pixel consumer.
module video_fetch #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic [2:0]  mc,
  input  logic [15:0] sram_d,
  input  logic        line_start,
  input  logic [17:0] base_addr,
  input  logic [7:0]  words,
  output logic [17:0] vaddr,
  input  logic        pix_rd,
  output logic [15:0] pix_d,
  output logic        pix_vld,
  output logic        busy,
  output logic        underrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [7:0]    remaining;
  logic          pending;
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  logic          issue, capture, pop_do, pop_empty;

  // Words already buffered plus the one in flight decide whether another
  // address may be issued.
  assign occ    = {1'b0, count} + (CW + 1)'(pending);
  assign rd_nxt = rd_ptr + AW'(1);

  // State register.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and per-edge actions; line_start overrides every other action.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    capture   = 1'b0;
    pop_do    = 1'b0;
    pop_empty = 1'b0;
    if (line_start) begin
      state_nxt = (words == 8'd0) ? IDLE : FETCH;
    end else begin
      issue     = (state == FETCH) && mc[0] && !mc[1] &&
                  (occ < (CW + 1)'(FIFO_DEPTH));
      capture   = mc[2] && !mc[1] && pending;
      pop_do    = pix_rd && (count != '0);
      pop_empty = pix_rd && (count == '0);
      if (issue && remaining == 8'd1) state_nxt = DRAIN;
      if (capture && state == DRAIN)  state_nxt = IDLE;
    end
  end

  // Address generation, FIFO bookkeeping, head register and underrun flag.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      vaddr     <= '0;
      remaining <= '0;
      pending   <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pix_d     <= '0;
      underrun  <= 1'b0;
    end else if (line_start) begin
      vaddr     <= base_addr;
      remaining <= words;
      pending   <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      underrun  <= 1'b0;
    end else begin
      if (capture) begin
        pending <= 1'b0;
        wr_ptr  <= wr_ptr + AW'(1);
      end
      if (issue) begin
        pending   <= 1'b1;
        vaddr     <= vaddr + 18'd1;
        remaining <= remaining - 8'd1;
      end
      if (pop_do)    rd_ptr   <= rd_nxt;
      if (pop_empty) underrun <= 1'b1;
      case ({capture, pop_do})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // The captured word becomes the head when nothing else remains ahead
      // of it; otherwise a pop exposes the next stored word.
      if (capture && (count == '0 || (count == CW'(1) && pop_do)))
        pix_d <= sram_d;
      else if (pop_do && count > CW'(1))
        pix_d <= mem[rd_nxt];
    end
  end

  // FIFO storage; contents need no reset because count gates visibility.
  always_ff @(posedge mclk) begin
    if (capture) mem[wr_ptr] <= sram_d;
  end

  assign pix_vld = (count != '0);
  assign busy    = (state != IDLE);

endmodule
